// File: rtl/seq_alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_NEG  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_DIV  = 4'b0111;

  // Opcode bit that selects the shift group; the lower bits then encode the shift.
  localparam int OP_SHIFT_MSB = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative shift-add multiplier and (with SEQ_ALU_DIV_EN) restoring divider.
// One iteration per cycle after start; last_o flags the final iteration.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
`ifdef SEQ_ALU_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] res_o,
  output logic             hi_nz_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH:0]   mul_sum;

`ifdef SEQ_ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   rem_sh, rem_sub;
`endif

  // hi:lo is the partial product (MUL) or remainder:quotient (DIV).
  always_comb begin
    mul_sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opnd_q};
    if (div_q) begin
      if (rem_sh >= {1'b0, opnd_q}) begin
        hi_d = rem_sub[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = rem_sh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // NOTE: datapath registers carry no reset; the counter alone decides when they matter.
  always_ff @(posedge clk) begin
    if (start_i) begin
      hi_q   <= '0;
      lo_q   <= a_i;
      opnd_q <= b_i;
`ifdef SEQ_ALU_DIV_EN
      div_q  <= div_i;
`endif
    end else if (cnt_q != '0) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign last_o  = (cnt_q == CW'(1));
  assign res_o   = lo_d;
  assign hi_nz_o = |hi_d;

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle simple ops, WIDTH-cycle MUL and
// optional DIV (enabled by the SEQ_ALU_DIV_EN macro; otherwise op 0111 passes a).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             f_zero,
  output logic             f_sign,
  output logic             f_carry
);

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] simple_res;
  logic             simple_carry;
  logic             use_iter;
  logic             accept, iter_start;
  logic             iter_last, iter_hi_nz;
  logic [WIDTH-1:0] iter_res;

`ifdef SEQ_ALU_DIV_EN
  logic             div_op, div_q, bz_q;
`endif

  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    simple_res   = a;
    simple_carry = 1'b0;
    use_iter     = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    div_op       = 1'b0;
`endif
    amt          = op[2] ? shamt : b[SHW-1:0];
    if (op[OP_SHIFT_MSB]) begin
      if (!op[1])     simple_res = a << amt;
      else if (op[0]) simple_res = $signed(a) >>> amt;
      else            simple_res = a >> amt;
    end else begin
      case (op)
        OP_ADD: {simple_carry, simple_res} = {1'b0, a} + {1'b0, b};
        OP_AND: simple_res = a & b;
        OP_XOR: simple_res = a ^ b;
        OP_MUL: use_iter = 1'b1;
        OP_NEG: {simple_carry, simple_res} = {1'b0, ~b} + (WIDTH+1)'(1);
        OP_SUB: begin
          simple_res   = a - b;
          simple_carry = (a < b);
        end
`ifdef SEQ_ALU_DIV_EN
        OP_DIV: begin
          use_iter = 1'b1;
          div_op   = 1'b1;
        end
`endif
        default: simple_res = a;
      endcase
    end
  end

  assign accept     = (state_q == IDLE) && in_valid;
  assign iter_start = accept && use_iter;

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (iter_start),
`ifdef SEQ_ALU_DIV_EN
    .div_i   (div_op),
`endif
    .a_i     (a),
    .b_i     (b),
    .last_o  (iter_last),
    .res_o   (iter_res),
    .hi_nz_o (iter_hi_nz)
  );

  // The DONE transition on the final iteration writes the iterator's next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          if (use_iter) begin
            state_q <= BUSY;
`ifdef SEQ_ALU_DIV_EN
            div_q   <= div_op;
            bz_q    <= (b == '0);
`endif
          end else begin
            state_q  <= DONE;
            result_q <= simple_res;
            carry_q  <= simple_carry;
          end
        end
        BUSY: if (iter_last) begin
          state_q  <= DONE;
          result_q <= iter_res;
`ifdef SEQ_ALU_DIV_EN
          carry_q  <= div_q ? bz_q : iter_hi_nz;
`else
          carry_q  <= iter_hi_nz;
`endif
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign f_carry   = carry_q;
  assign f_zero    = (result_q == '0);
  assign f_sign    = result_q[WIDTH-1];

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded random + directed bench for seq_alu (WIDTH=32); follows SEQ_ALU_DIV_EN.
module tb_seq_alu;

`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic [4:0]  shamt;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        f_zero, f_sign, f_carry;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .f_zero(f_zero), .f_sign(f_sign), .f_carry(f_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        c;
    int          lat;
    int          req;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rand_rdy = 1'b0;
  logic rdy_fixed = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the opcode table.
  function automatic void model(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                                input logic [4:0] sv, output logic [31:0] r, output logic c,
                                output int lat);
    longint unsigned ua, ub, t;
    int amt;
    ua = 64'(av);
    ub = 64'(bv);
    r = av; c = 1'b0; lat = 1;
    if (o[3]) begin
      amt = o[2] ? int'(sv) : int'(bv % 32);
      if (!o[1])     r = av << amt;
      else if (o[0]) r = $signed(av) >>> amt;
      else           r = av >> amt;
    end else begin
      case (o)
        4'd1: begin t = ua + ub; r = t[31:0]; c = (t > 64'hFFFF_FFFF); end
        4'd2: r = av & bv;
        4'd3: r = av ^ bv;
        4'd4: begin t = ua * ub; r = t[31:0]; c = ((t >> 32) != 0); lat = 33; end
        4'd5: begin t = 64'h1_0000_0000 - ub; r = t[31:0]; c = (ub == 0); end
        4'd6: begin r = av - bv; c = (ua < ub); end
        4'd7: if (DIV_EN) begin
          lat = 33;
          if (bv == 0) begin r = 32'hFFFF_FFFF; c = 1'b1; end
          else r = av / bv;
        end
        default: r = av;
      endcase
    end
  endfunction

  // Monitor: pops an expectation when a result first appears, then checks it stays put.
  exp_t cur;
  bit   have = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      have = 1'b0;
    end else if (out_valid) begin
      if (!have) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got result %0h with no request outstanding", result);
          cur.r = result; cur.c = f_carry;
        end else begin
          cur = q.pop_front();
          check("result", 64'(result), 64'(cur.r));
          check("carry", 64'(f_carry), 64'(cur.c));
          check("zero", 64'(f_zero), 64'(cur.r == 0));
          check("sign", 64'(f_sign), 64'(cur.r[31]));
          check("latency", 64'(cyc - cur.req), 64'(cur.lat));
        end
        have = 1'b1;
      end else begin
        check("hold", {31'd0, result, f_carry}, {31'd0, cur.r, cur.c});
      end
      if (out_ready) have = 1'b0;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] sv);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready got 0, expected 1 within 200 cycles");
      return;
    end
    model(o, av, bv, sv, e.r, e.c, e.lat);
    e.req = cyc;
    q.push_back(e);
    in_valid = 1'b1; op = o; a = av; b = bv; shamt = sv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom); shamt = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 64'(q.size() != 0 || out_valid), 64'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_result", 64'(result), 64'(0));
    check("rst_zero", 64'(f_zero), 64'(1));
    check("rst_sign", 64'(f_sign), 64'(0));
    check("rst_carry", 64'(f_carry), 64'(0));

    // Abort a multiply with reset mid-flight.
    issue(4'b0100, 32'd7, 32'd9, 5'd0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_result", 64'(result), 64'(0));
    issue(4'b0001, 32'd1, 32'd2, 5'd0);
    drain();

    // Carry-out with a stalled consumer.
    rdy_fixed = 1'b0;
    issue(4'b0001, 32'hFFFF_FFFF, 32'd1, 5'd0);
    repeat (6) @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    drain();

    issue(4'b0110, 32'd3, 32'd5, 5'd0);
    issue(4'b0101, 32'h1234_5678, 32'd0, 5'd0);
    issue(4'b0100, 32'h0001_0000, 32'h0001_0000, 5'd0);
    issue(4'b0100, 32'd6, 32'd7, 5'd0);
    issue(4'b1111, 32'h8000_0000, 32'd0, 5'd4);
    issue(4'b1010, 32'h8000_0000, 32'd36, 5'd9);
    issue(4'b1100, 32'hDEAD_BEEF, 32'd0, 5'd0);
    issue(4'b0111, 32'd100, 32'd7, 5'd0);
    issue(4'b0111, 32'd5, 32'd0, 5'd0);
    issue(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
    issue(4'b0011, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'd0);
    drain();

    // Requests held during BUSY must be ignored until the result is consumed.
    rdy_fixed = 1'b0;
    issue(4'b0100, 32'd123, 32'd456, 5'd0);
    in_valid = 1'b1; op = 4'b0001; a = 32'd1; b = 32'd1;
    repeat (40) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_fixed = 1'b1;
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      issue(4'($urandom_range(0, 15)), ra, rb, 5'($urandom));
    end
    drain();
    rand_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
